// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcodes, field positions and FSM state encoding
package instr_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BRZ  = 4'h4;
    localparam logic [3:0] OP_BRN  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DR_MSB  = 11;
    localparam int DR_LSB  = 9;
    localparam int SA_MSB  = 8;
    localparam int SA_LSB  = 6;
    localparam int FS_MSB  = 5;
    localparam int FS_LSB  = 3;
    localparam int SB_MSB  = 2;
    localparam int SB_LSB  = 0;
    localparam int OFF_MSB = 5;
    localparam int OFF_LSB = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH    = 3'd0;
    localparam state_t ST_DECODE   = 3'd1;
    localparam state_t ST_EXEC     = 3'd2;
    localparam state_t ST_MEM_WAIT = 3'd3;
    localparam state_t ST_WB       = 3'd4;
    localparam state_t ST_HALT     = 3'd5;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational field extraction and opcode classification
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  dr,
    output logic [2:0]  sa,
    output logic [2:0]  sb,
    output logic [2:0]  fs,
    output logic [5:0]  offset,
    output logic        is_alu,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_br,
    output logic        is_jmp,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] w_op;

    assign w_op   = ir[OP_MSB:OP_LSB];
    assign dr     = ir[DR_MSB:DR_LSB];
    assign sa     = ir[SA_MSB:SA_LSB];
    assign sb     = ir[SB_MSB:SB_LSB];
    assign fs     = ir[FS_MSB:FS_LSB];
    assign offset = ir[OFF_MSB:OFF_LSB];

    // Classify the opcode; anything unlisted is illegal and behaves as a NOP
    always_comb begin
        is_alu     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_br      = 1'b0;
        is_jmp     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (w_op)
            OP_NOP:  ;
            OP_ALU:  is_alu  = 1'b1;
            OP_LD:   is_ld   = 1'b1;
            OP_ST:   is_st   = 1'b1;
            OP_BRZ:  is_br   = 1'b1;
            OP_BRN:  is_br   = 1'b1;
            OP_JMP:  is_jmp  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute control sequencer
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] instr,
    input  logic                 imem_valid,
    input  logic                 zero,
    input  logic                 negative,
    input  logic                 mem_ready,
    output logic [BUS_WIDTH-1:0] ir,
    output logic [2:0]           dr,
    output logic [2:0]           sa,
    output logic [2:0]           sb,
    output logic [2:0]           fs,
    output logic [5:0]           offset,
    output logic                 PL,
    output logic                 JB,
    output logic                 pc_en,
    output logic                 rf_we,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [15:0]          retired
);

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_ir;
    logic [7:0]           r_wait_cnt;
    logic [15:0]          r_retired;
    logic                 r_illegal;
    logic                 r_bus_err;

    state_t w_next;
    logic   w_is_alu, w_is_ld, w_is_st, w_is_br, w_is_jmp, w_is_halt, w_is_illegal;
    logic   w_taken;
    logic   w_timeout;
    logic   w_retire;
    logic   w_exec, w_wait, w_wb;

    instr_decode u_decode (
        .ir         (r_ir),
        .dr         (dr),
        .sa         (sa),
        .sb         (sb),
        .fs         (fs),
        .offset     (offset),
        .is_alu     (w_is_alu),
        .is_ld      (w_is_ld),
        .is_st      (w_is_st),
        .is_br      (w_is_br),
        .is_jmp     (w_is_jmp),
        .is_halt    (w_is_halt),
        .is_illegal (w_is_illegal)
    );

    assign w_exec = (r_state == ST_EXEC);
    assign w_wait = (r_state == ST_MEM_WAIT);
    assign w_wb   = (r_state == ST_WB);

    // BRZ tests zero, BRN tests negative; flags only matter while in EXEC
    assign w_taken   = (r_ir[OP_MSB:OP_LSB] == OP_BRZ) ? zero : negative;
    // mem_ready on the last allowed cycle takes priority over the timeout
    assign w_timeout = w_wait && !mem_ready && (r_wait_cnt == 8'(MEM_TIMEOUT - 1));
    // An instruction retires on its return to FETCH; HALT retires on entry to HALT
    assign w_retire  = w_wb || (w_exec && (w_is_br || w_is_jmp || w_is_halt));

    // Next-state selection for the instruction sequencing FSM
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    if (imem_valid) w_next = ST_DECODE;
            ST_DECODE:   w_next = ST_EXEC;
            ST_EXEC: begin
                if (w_is_br || w_is_jmp)      w_next = ST_FETCH;
                else if (w_is_ld || w_is_st)  w_next = ST_MEM_WAIT;
                else if (w_is_halt)           w_next = ST_HALT;
                else                          w_next = ST_WB;
            end
            ST_MEM_WAIT: begin
                if (mem_ready)      w_next = ST_WB;
                else if (w_timeout) w_next = ST_HALT;
            end
            ST_WB:       w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            default:     w_next = ST_FETCH;
        endcase
    end

    // State, instruction latch, wait counter, retire counter and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_ir       <= '0;
            r_wait_cnt <= '0;
            r_retired  <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH && imem_valid)
                r_ir <= instr;
            if (w_wait)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= '0;
            if (w_retire)
                r_retired <= r_retired + 16'd1;
            if (w_exec && w_is_illegal)
                r_illegal <= 1'b1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    // Strobes decode from the current state so a reset removes them at once
    assign PL     = w_exec && ((w_is_br && w_taken) || w_is_jmp);
    assign JB     = w_exec && w_is_jmp;
    assign pc_en  = (w_exec && w_is_br && !w_taken) || w_wb;
    assign rf_we  = w_wb && (w_is_alu || w_is_ld);
    assign mem_re = w_wait && w_is_ld;
    assign mem_we = w_wait && w_is_st;

    assign ir      = r_ir;
    assign halted  = (r_state == ST_HALT);
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        imem_valid = 1'b0;
    logic        zero = 1'b0;
    logic        negative = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] ir;
    logic [2:0]  dr, sa, sb, fs;
    logic [5:0]  offset;
    logic        PL, JB, pc_en, rf_we, mem_re, mem_we;
    logic        halted, illegal, bus_err;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.BUS_WIDTH(16), .MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .imem_valid (imem_valid),
        .zero       (zero),
        .negative   (negative),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .dr         (dr),
        .sa         (sa),
        .sb         (sb),
        .fs         (fs),
        .offset     (offset),
        .PL         (PL),
        .JB         (JB),
        .pc_en      (pc_en),
        .rf_we      (rf_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // strobe vector order: PL JB pc_en rf_we mem_re mem_we
    function automatic logic [5:0] strobes();
        return {PL, JB, pc_en, rf_we, mem_re, mem_we};
    endfunction

    function automatic logic [2:0] flags();
        return {halted, illegal, bus_err};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one instruction in FETCH; returns at the DECODE negedge with valid dropped
    task automatic fetch(input logic [15:0] word);
        instr      = word;
        imem_valid = 1'b1;
        step();
        imem_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic run_branch(input string tag, input logic [15:0] word, input logic z, input logic n,
                              input logic [5:0] exp_exec, input logic [15:0] exp_ret);
        fetch(word);
        step();
        zero = z;
        negative = n;
        #1;
        check_eq({tag, "_exec_strobes"}, 32'(strobes()), 32'(exp_exec));
        step();
        zero = 1'b0;
        negative = 1'b0;
        check_eq({tag, "_after_strobes"}, 32'(strobes()), 32'h0);
        check_eq({tag, "_retired"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        step();
        step();
        check_eq("rst_ir", 32'(ir), 32'h0);
        check_eq("rst_retired", 32'(retired), 32'h0);
        check_eq("rst_strobes", 32'(strobes()), 32'h0);
        check_eq("rst_flags", 32'(flags()), 32'h0);
        check_eq("rst_fields", {14'h0, dr, sa, sb, fs, offset}, 32'h0);
        reset = 1'b0;
        step();

        // ALU 0x1A5B: dr=5 sa=1 sb=3 fs=3; WB in cycle 4
        fetch(16'h1A5B);
        check_eq("alu_ir", 32'(ir), 32'h1A5B);
        check_eq("alu_fields", {20'h0, dr, sa, sb, fs}, {20'h0, 3'd5, 3'd1, 3'd3, 3'd3});
        check_eq("alu_decode_strobes", 32'(strobes()), 32'h0);
        step();
        check_eq("alu_exec_strobes", 32'(strobes()), 32'h0);
        step();
        check_eq("alu_wb_strobes", 32'(strobes()), 32'b00_1100);
        step();
        check_eq("alu_after_strobes", 32'(strobes()), 32'h0);
        check_eq("alu_retired", 32'(retired), 32'd1);
        step();
        step();
        check_eq("idle_ir_held", 32'(ir), 32'h1A5B);
        check_eq("idle_strobes", 32'(strobes()), 32'h0);

        run_branch("brz_taken", 16'h403C, 1'b1, 1'b0, 6'b100000, 16'd2);
        check_eq("brz_offset", 32'(offset), 32'h3C);
        run_branch("brz_not", 16'h403C, 1'b0, 1'b1, 6'b001000, 16'd3);
        run_branch("brn_taken", 16'h5001, 1'b0, 1'b1, 6'b100000, 16'd4);

        // JMP 0x6080: sa=2, PL+JB for exactly one cycle
        fetch(16'h6080);
        check_eq("jmp_sa", 32'(sa), 32'd2);
        step();
        check_eq("jmp_exec_strobes", 32'(strobes()), 32'b110000);
        step();
        check_eq("jmp_after_strobes", 32'(strobes()), 32'h0);
        check_eq("jmp_retired", 32'(retired), 32'd5);

        // LD with mem_ready on the final allowed wait cycle: ready wins
        fetch(16'h2A00);
        step();
        check_eq("ld_exec_strobes", 32'(strobes()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("ld_wait_mem_re", 32'(strobes()), 32'b000010);
        end
        step();
        mem_ready = 1'b1;
        #1;
        check_eq("ld_last_wait_mem_re", 32'(strobes()), 32'b000010);
        step();
        mem_ready = 1'b0;
        check_eq("ld_wb_strobes", 32'(strobes()), 32'b001100);
        check_eq("ld_no_bus_err", 32'(flags()), 32'h0);
        step();
        check_eq("ld_retired", 32'(retired), 32'd6);

        // ST interrupted by reset while waiting on memory
        fetch(16'h3000);
        step();
        step();
        check_eq("st_wait_mem_we", 32'(strobes()), 32'b000001);
        #2 reset = 1'b1;
        #1;
        check_eq("st_rst_strobes", 32'(strobes()), 32'h0);
        check_eq("st_rst_retired", 32'(retired), 32'h0);
        check_eq("st_rst_ir", 32'(ir), 32'h0);
        check_eq("st_rst_flags", 32'(flags()), 32'h0);
        step();
        reset = 1'b0;
        step();

        // NOP, then illegal 0x9000, then HALT 0xF000
        fetch(16'h0000);
        step();
        step();
        check_eq("nop_wb_strobes", 32'(strobes()), 32'b001000);
        step();
        check_eq("nop_retired", 32'(retired), 32'd1);
        fetch(16'h9000);
        step();
        check_eq("ill_exec_strobes", 32'(strobes()), 32'h0);
        step();
        check_eq("ill_wb_strobes", 32'(strobes()), 32'b001000);
        check_eq("ill_flag", 32'(illegal), 32'd1);
        step();
        check_eq("ill_after_strobes", 32'(strobes()), 32'h0);
        fetch(16'hF000);
        step();
        check_eq("halt_exec_strobes", 32'(strobes()), 32'h0);
        instr = 16'h1A5B;
        imem_valid = 1'b1;
        step();
        check_eq("halt_flags", 32'(flags()), 32'b110);
        check_eq("halt_retired", 32'(retired), 32'd3);
        for (int i = 0; i < 4; i++) step();
        check_eq("halt_stays", 32'(halted), 32'd1);
        check_eq("halt_ir_held", 32'(ir), 32'hF000);
        check_eq("halt_strobes", 32'(strobes()), 32'h0);
        check_eq("halt_retired_held", 32'(retired), 32'd3);
        imem_valid = 1'b0;

        // LD timeout with MEM_TIMEOUT=4
        do_reset();
        fetch(16'h2000);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("to_wait_mem_re", 32'(strobes()), 32'b000010);
        end
        instr = 16'h1000;
        imem_valid = 1'b1;
        step();
        check_eq("to_flags", 32'(flags()), 32'b101);
        check_eq("to_strobes", 32'(strobes()), 32'h0);
        step();
        step();
        check_eq("to_no_fetch", 32'(ir), 32'h2000);
        check_eq("to_retired", 32'(retired), 32'h0);
        imem_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
